// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: byte width and the slave FSM state encoding.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_slv_state_t;
endpackage

// File: rtl/spi_input_sync.sv
// Synchronizer chain for one asynchronous pin plus rise/fall detection on the synchronized level.
module spi_input_sync
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      dly   <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_slave_cpol0_cpha0.sv
// SPI mode-0 slave, MSB first: oversampled pins, byte receive strobe, single-entry transmit buffer.
module spi_slave_cpol0_cpha0
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_abort,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam logic [SPI_CNT_W-1:0] BIT_LAST = SPI_CNT_W'(SPI_BYTE_W - 1);

  logic sel_lvl, sel_rise, sel_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic sync_unused;

  // ss_n idles high, so its chain resets high to avoid a false select after reset.
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
    .clk(clk), .rst(rst), .pin(ss_n), .level(sel_lvl), .rise(sel_rise), .fall(sel_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .pin(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = &{sel_lvl, sclk_lvl, mosi_rise, mosi_fall};

  spi_slv_state_t        state, state_n;
  logic [SPI_CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [SPI_BYTE_W-1:0] rx_shift, rx_shift_n;
  logic [SPI_BYTE_W-1:0] tx_shift, tx_shift_n;
  logic [SPI_BYTE_W-1:0] buf_data, buf_data_n;
  logic                  buf_full, buf_full_n;
  logic [SPI_BYTE_W-1:0] rx_data_n;
  logic                  rx_valid_n, rx_abort_n, underrun_n, load;

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rx_shift_n = rx_shift;
    tx_shift_n = tx_shift;
    buf_data_n = buf_data;
    buf_full_n = buf_full;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rx_abort_n = 1'b0;
    underrun_n = 1'b0;
    load       = 1'b0;

    if (tx_valid && !buf_full) begin
      buf_data_n = tx_data;
      buf_full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (sel_fall) begin
          state_n   = ACTIVE;
          bit_cnt_n = '0;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect takes priority over a coincident sclk edge.
        if (sel_rise) begin
          state_n = IDLE;
          if (bit_cnt != '0) begin
            rx_abort_n = 1'b1;
            bit_cnt_n  = '0;
            rx_shift_n = '0;
          end
        end else if (sclk_rise) begin
          rx_shift_n = {rx_shift[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_n  = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            rx_data_n  = {rx_shift[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_n = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt != '0) tx_shift_n = {tx_shift[SPI_BYTE_W-2:0], 1'b0};
          else               load       = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A consume only happens with the buffer full, so it never collides with a write.
    if (load) begin
      if (buf_full) begin
        tx_shift_n = buf_data;
        buf_full_n = 1'b0;
      end else begin
        tx_shift_n = '0;
        underrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;
      miso        <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      rx_shift    <= rx_shift_n;
      tx_shift    <= tx_shift_n;
      buf_data    <= buf_data_n;
      buf_full    <= buf_full_n;
      rx_data     <= rx_data_n;
      rx_valid    <= rx_valid_n;
      rx_abort    <= rx_abort_n;
      tx_underrun <= underrun_n;
      miso        <= (state_n == ACTIVE) & tx_shift_n[SPI_BYTE_W-1];
    end
  end

  assign miso_oe  = (state == ACTIVE);
  assign busy     = (state == ACTIVE);
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave_cpol0_cpha0.sv
// Scoreboard bench for the SPI mode-0 slave: a bench-side master at clk/8 and a host tx writer.
module tb_spi_slave_cpol0_cpha0;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, ss_n, sclk, mosi;
  logic       miso, miso_oe, tx_ready, tx_valid;
  logic [7:0] tx_data, rx_data;
  logic       rx_valid, rx_abort, tx_underrun, busy;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_abort = 0, n_under = 0;
  int b_valid, b_abort, b_under;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] mo_q[$];

  spi_slave_cpol0_cpha0 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_abort(rx_abort), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Receive-side scoreboard and strobe counters.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_valid++;
        if (exp_rx.size() == 0) check("rx_spurious", {31'b0, rx_valid}, 32'd0);
        else check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (rx_abort)    n_abort++;
      if (tx_underrun) n_under++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic snap();
    b_valid = n_valid; b_abort = n_abort; b_under = n_under;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int da, input int du);
    check({tag, "_valid"}, n_valid - b_valid, dv);
    check({tag, "_abort"}, n_abort - b_abort, da);
    check({tag, "_under"}, n_under - b_under, du);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("tx_ready_timeout", {31'b0, tx_ready}, 32'd1);
  endtask

  task automatic load_tx(input logic [7:0] d);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, {31'b0, miso}, 32'd0);
    check({tag, "_oe"}, {31'b0, miso_oe}, 32'd0);
    check({tag, "_rx_data"}, rx_data, 32'h00);
    check({tag, "_strobes"}, {29'b0, rx_valid, rx_abort, tx_underrun}, 32'd0);
    check({tag, "_ready"}, {31'b0, tx_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // Full frame of n bytes from mo_q; the last sclk fall coincides with ss_n rising.
  task automatic spi_frame(input int n);
    logic [7:0] mo, mi;
    ss_n = 1'b0;
    for (int b = 0; b < n; b++) begin
      mo = mo_q.pop_front();
      exp_rx.push_back(mo);
      for (int i = 7; i >= 0; i--) begin
        mosi = mo[i];
        repeat (HALF) @(negedge clk);
        mi[i] = miso;
        if (i == 7) check("miso_oe_active", {31'b0, miso_oe}, 32'd1);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        if (b == n - 1 && i == 0) ss_n = 1'b1;
      end
      if (exp_miso.size() == 0) check("miso_no_exp", exp_miso.size(), 32'd1);
      else check("miso_byte", mi, exp_miso.pop_front());
    end
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_partial(input logic [7:0] mo, input int nrise);
    ss_n = 1'b0;
    for (int i = 7; i > 7 - nrise; i--) begin
      mosi = mo[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte
    load_tx(8'hA5);
    exp_miso.push_back(8'hA5);
    mo_q.push_back(8'h3C);
    snap();
    spi_frame(1);
    check_deltas("single", 1, 0, 0);
    check("single_rx_data", rx_data, 32'h3C);
    check("single_ready", {31'b0, tx_ready}, 32'd1);

    // Back-to-back bytes, host refills as tx_ready allows
    load_tx(8'h11);
    exp_miso.push_back(8'h11); exp_miso.push_back(8'h22); exp_miso.push_back(8'h33);
    mo_q.push_back(8'h01); mo_q.push_back(8'h80); mo_q.push_back(8'hFF);
    snap();
    fork
      spi_frame(3);
      begin
        load_tx(8'h22);
        load_tx(8'h33);
      end
    join
    check_deltas("b2b", 3, 0, 0);
    check("b2b_rx_data", rx_data, 32'hFF);

    // Underrun
    load_tx(8'h5A);
    exp_miso.push_back(8'h5A); exp_miso.push_back(8'h00);
    mo_q.push_back(8'hC3); mo_q.push_back(8'h7E);
    snap();
    spi_frame(2);
    check_deltas("underrun", 2, 0, 1);

    // Abort after 5 rises; buffer empty so the frame start underruns
    snap();
    spi_partial(8'hB6, 5);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check_deltas("abort", 0, 1, 1);
    check("abort_rx_data", rx_data, 32'h7E);
    check("abort_busy", {31'b0, busy}, 32'd0);
    load_tx(8'h96);
    exp_miso.push_back(8'h96);
    mo_q.push_back(8'h4D);
    snap();
    spi_frame(1);
    check_deltas("post_abort", 1, 0, 0);
    check("post_abort_rx", rx_data, 32'h4D);

    // Reset during bit 4
    load_tx(8'hE7);
    spi_partial(8'hAA, 4);
    mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    load_tx(8'h3A);
    exp_miso.push_back(8'h3A);
    mo_q.push_back(8'h5C);
    snap();
    spi_frame(1);
    check_deltas("post_rst", 1, 0, 0);
    check("post_rst_rx", rx_data, 32'h5C);

    // Idle noise: sclk toggles with ss_n high
    snap();
    for (int i = 0; i < 10; i++) begin
      mosi = i[0];
      sclk = ~sclk;
      repeat (HALF) @(negedge clk);
      check("idle_miso_oe", {30'b0, miso, miso_oe}, 32'd0);
    end
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    check_deltas("idle", 0, 0, 0);
    check("idle_busy", {31'b0, busy}, 32'd0);

    check("rx_pending", exp_rx.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
